maf_spec_pipe: RTL

Parametrised special-case pipeline for the single-precision multiply-add datapath (a×b+c). It classifies the three IEEE-754 operands at issue and resolves every input combination whose result is fixed by the operand classes alone: NaN, infinity, invalid, zero product and zero sum. The resolved result travels alongside the main arithmetic pipeline through LAT stages with valid/ready backpressure, so the final stage selects it over the rounded result. It generalises the fixed four-stage, stall-free multiply-add pipeline in two ways: depth is configurable, and downstream stalls are supported.

---
 rtl/maf_pkg.sv | 30 +++
 rtl/maf_classify.sv | 31 +++
 rtl/maf_spec_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/maf_pkg.sv
// Shared types and constants for the multiply-add special-case datapath.
package maf_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned TAG_MAX_W = 16;
    localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_e;

    // Tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
    typedef struct packed {
        logic                 vld;
        logic                 hit;
        logic [31:0]          res;
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

    function automatic logic is_nan(input cls_e cls);
        return (cls == CLS_QNAN) || (cls == CLS_SNAN);
    endfunction

endpackage

// File: rtl/maf_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
module maf_classify
    import maf_pkg::*;
(
    input  logic [31:0] i_op,
    input  logic        i_nj_mode,
    output cls_e        o_cls,
    output logic        o_sign
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    assign w_exp  = i_op[30:23];
    assign w_frac = i_op[22:0];
    assign o_sign = i_op[31];

    always_comb begin
        o_cls = CLS_NORM;
        if (w_exp == '0) begin
            if (w_frac == '0)   o_cls = CLS_ZERO;
            else if (i_nj_mode) o_cls = CLS_ZERO;
            else                o_cls = CLS_DENORM;
        end else if (w_exp == '1) begin
            if (w_frac == '0)   o_cls = CLS_INF;
            else if (w_frac[FRAC_W-1]) o_cls = CLS_QNAN;
            else                o_cls = CLS_SNAN;
        end
    end

endmodule

// File: rtl/maf_spec_pipe.sv
// Special-case resolution for a*b+c, carried through a LAT-deep valid/ready pipeline.
module maf_spec_pipe
    import maf_pkg::*;
#(
    parameter int unsigned LAT   = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             nj_mode,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             spec_hit,
    output logic [31:0]      spec_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    cls_e w_cls_a, w_cls_b, w_cls_c;
    logic w_sa, w_sb, w_sc;

    maf_classify u_cls_a (.i_op(a), .i_nj_mode(nj_mode), .o_cls(w_cls_a), .o_sign(w_sa));
    maf_classify u_cls_b (.i_op(b), .i_nj_mode(nj_mode), .o_cls(w_cls_b), .o_sign(w_sb));
    maf_classify u_cls_c (.i_op(c), .i_nj_mode(nj_mode), .o_cls(w_cls_c), .o_sign(w_sc));

    logic        w_ps, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_c_inf, w_c_zero;
    logic        w_hit;
    logic [31:0] w_res;

    assign w_ps     = w_sa ^ w_sb;
    assign w_a_inf  = (w_cls_a == CLS_INF);
    assign w_b_inf  = (w_cls_b == CLS_INF);
    assign w_c_inf  = (w_cls_c == CLS_INF);
    assign w_a_zero = (w_cls_a == CLS_ZERO);
    assign w_b_zero = (w_cls_b == CLS_ZERO);
    assign w_c_zero = (w_cls_c == CLS_ZERO);

    always_comb begin
        w_hit = 1'b1;
        w_res = '0;
        if (is_nan(w_cls_a) || is_nan(w_cls_b) || is_nan(w_cls_c)) begin
            w_res = QNAN_CANON;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res = QNAN_CANON;
        end else if ((w_a_inf || w_b_inf) && w_c_inf && (w_ps != w_sc)) begin
            w_res = QNAN_CANON;
        end else if (w_a_inf || w_b_inf) begin
            w_res = {w_ps, 8'hFF, 23'h0};
        end else if (w_c_inf) begin
            w_res = c;
        end else if ((w_a_zero || w_b_zero) && w_c_zero) begin
            w_res = {w_ps & w_sc, 31'h0};
        end else if (w_a_zero || w_b_zero) begin
            w_res = c;
        end else begin
            w_hit = 1'b0;
        end
    end

    stage_t w_in;

    always_comb begin
        w_in     = '0;
        w_in.vld = in_vld;
        if (in_vld) begin
            w_in.hit             = w_hit;
            w_in.res             = w_res;
            w_in.tag[TAG_W-1:0]  = in_tag;
        end
    end

    stage_t         r_stg [LAT];
    logic [LAT-1:0] w_vld;
    logic [LAT-1:0] w_rdy;

    always_comb begin
        w_vld = '0;
        for (int unsigned i = 0; i < LAT; i++) w_vld[i] = r_stg[i].vld;
    end

    for (genvar g = 0; g < LAT; g++) begin : g_stg
        stage_t w_up;

        if (g == 0) begin : g_head
            assign w_up = w_in;
        end else begin : g_body
            assign w_up = r_stg[g-1];
        end

        // Unrolled form of rdy[g] = !vld[g] || rdy[g+1], avoiding a self-referencing vector.
        assign w_rdy[g] = out_rdy || !(&w_vld[LAT-1:g]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_stg[g] <= '0;
            else if (w_rdy[g]) r_stg[g] <= w_up;
        end
    end

    assign in_rdy   = w_rdy[0];
    assign out_vld  = r_stg[LAT-1].vld;
    assign spec_hit = r_stg[LAT-1].hit;
    assign spec_res = r_stg[LAT-1].res;
    assign out_tag  = r_stg[LAT-1].tag[TAG_W-1:0];
    assign busy     = |w_vld;

endmodule
